// File: rtl/kt_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kt_job_arbiter
// Purpose  : Shares one Knight's-Tour solver core among NREQ requesters.
//            Requesters are granted round-robin. The owner's prefix path is
//            streamed into the core load port. The core's 25-beat result
//            burst is returned tagged with the owner ID. Protocol, config,
//            sequencing and watchdog errors are flagged with sticky bits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req / gnt            per-requester job request / registered one-hot grant
//   s_valid / s_ready    per-requester prefix beat handshake
//   s_x, s_y             packed 3-bit square per requester
//   s_move_num, s_prio   prefix length / priority, sampled on the first beat
//   kt_in_*              registered core load port
//   kt_out_*             core result port
//   r_*                  result beats tagged with the owner ID
//   err_*, err_clr       sticky error flags and their synchronous clear
//   job_cnt              completed-job counter (wraps)
// ============================================================================
module kt_job_arbiter #(
  parameter int          NREQ    = 2,
  parameter int          IDW     = 1,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   s_valid,
  output logic [NREQ-1:0]   s_ready,
  input  logic [3*NREQ-1:0] s_x,
  input  logic [3*NREQ-1:0] s_y,
  input  logic [5*NREQ-1:0] s_move_num,
  input  logic [3*NREQ-1:0] s_prio,
  output logic              kt_in_valid,
  output logic [2:0]        kt_in_x,
  output logic [2:0]        kt_in_y,
  output logic [4:0]        kt_move_num,
  output logic [2:0]        kt_priority_num,
  input  logic              kt_out_valid,
  input  logic [2:0]        kt_out_x,
  input  logic [2:0]        kt_out_y,
  input  logic [4:0]        kt_move_out,
  output logic              r_valid,
  output logic [IDW-1:0]    r_id,
  output logic [2:0]        r_x,
  output logic [2:0]        r_y,
  output logic [4:0]        r_step,
  output logic              r_last,
  output logic              err_proto,
  output logic              err_cfg,
  output logic              err_seq,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [15:0]       job_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [4:0] MAX_MOVES = 5'd24;
  localparam logic [4:0] LAST_STEP = 5'd25;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [4:0]      mv_q, mv_d;
  logic [2:0]      prio_q, prio_d;
  logic [4:0]      beat_q, beat_d;
  logic [15:0]     wdog_q, wdog_d;
  logic [4:0]      exp_q, exp_d;
  logic            kin_valid_q, kin_valid_d;
  logic [2:0]      kin_x_q, kin_x_d, kin_y_q, kin_y_d, kin_prio_q, kin_prio_d;
  logic [4:0]      kin_mv_q, kin_mv_d;
  logic            rv_q, rv_d, rlast_q, rlast_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic [2:0]      rx_q, rx_d, ry_q, ry_d;
  logic [4:0]      rstep_q, rstep_d;
  logic            eproto_q, eproto_d, ecfg_q, ecfg_d;
  logic            eseq_q, eseq_d, eto_q, eto_d;
  logic [15:0]     jobs_q, jobs_d;

  // Owner's slice of the packed requester buses
  logic       own_valid;
  logic [2:0] own_x, own_y, own_prio;
  logic [4:0] own_mv;

  always_comb begin : p_owner_mux
    own_valid = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_mv    = '0;
    own_prio  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_valid = s_valid[i];
        own_x     = s_x[3*i +: 3];
        own_y     = s_y[3*i +: 3];
        own_mv    = s_move_num[5*i +: 5];
        own_prio  = s_prio[3*i +: 3];
      end
    end
  end

  // Round-robin pick: first requester searching from last_grant+1
  logic           found;
  logic [IDW-1:0] pick, cand;

  always_comb begin : p_rr_pick
    found = 1'b0;
    pick  = last_grant_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (IDW'(i) == cand)) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
  end

  // Shared transition conditions
  logic       acc, first, cfg_bad, load_done, gap, out_beat, drain_last;
  logic [4:0] target_mv;

  assign acc        = (state_q == S_LOAD) && own_valid;
  assign first      = (beat_q == 5'd0);
  assign cfg_bad    = (own_mv == 5'd0) || (own_mv > MAX_MOVES);
  assign target_mv  = first ? own_mv : mv_q;
  assign load_done  = acc && !(first && cfg_bad) && ((beat_q + 5'd1) == target_mv);
  // A missing beat is only a gap once the prefix has started
  assign gap        = (state_q == S_LOAD) && !first && !own_valid;
  assign out_beat   = kt_out_valid && ((state_q == S_WAIT) || (state_q == S_DRAIN));
  assign drain_last = out_beat && (exp_q == LAST_STEP);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_LOAD;
      S_LOAD: begin
        if (acc && first && cfg_bad)  state_d = S_IDLE;
        else if (load_done || gap)    state_d = S_WAIT;
      end
      S_WAIT:  if (kt_out_valid) state_d = S_DRAIN;
      S_DRAIN: if (drain_last)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (gnt_q is the owner's one-hot)
  always_comb begin : p_fsm_out
    s_ready = (state_q == S_LOAD) ? gnt_q : '0;
  end

  // Datapath next-state
  always_comb begin : p_datapath
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mv_d         = mv_q;
    prio_d       = prio_q;
    beat_d       = beat_q;
    wdog_d       = wdog_q;
    exp_d        = exp_q;
    kin_valid_d  = 1'b0;
    kin_x_d      = kin_x_q;
    kin_y_d      = kin_y_q;
    kin_mv_d     = kin_mv_q;
    kin_prio_d   = kin_prio_q;
    rv_d         = 1'b0;
    rlast_d      = 1'b0;
    rid_d        = rid_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    rstep_d      = rstep_q;
    jobs_d       = jobs_q;
    // Clear first; events below override so a same-cycle event wins
    eproto_d     = err_clr ? 1'b0 : eproto_q;
    ecfg_d       = err_clr ? 1'b0 : ecfg_q;
    eseq_d       = err_clr ? 1'b0 : eseq_q;
    eto_d        = err_clr ? 1'b0 : eto_q;

    if (state_q != S_WAIT) wdog_d = '0;

    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        exp_d  = 5'd1;
        if (found) begin
          owner_d = pick;
          for (int i = 0; i < NREQ; i++) gnt_d[i] = (IDW'(i) == pick);
        end
      end
      S_LOAD: begin
        if (acc) begin
          if (first && cfg_bad) begin
            ecfg_d = 1'b1;
            gnt_d  = '0;
          end else begin
            if (first) begin
              mv_d   = own_mv;
              prio_d = own_prio;
            end
            kin_valid_d = 1'b1;
            kin_x_d     = own_x;
            kin_y_d     = own_y;
            kin_mv_d    = first ? own_mv : mv_q;
            kin_prio_d  = first ? own_prio : prio_q;
            beat_d      = beat_q + 5'd1;
          end
        end else if (gap) begin
          eproto_d = 1'b1;
        end
      end
      S_WAIT: begin
        // Saturates at TIMEOUT; err_timeout stays set until cleared
        if (wdog_q != TIMEOUT) begin
          wdog_d = wdog_q + 16'd1;
          if ((wdog_q + 16'd1) == TIMEOUT) eto_d = 1'b1;
        end
      end
      default: begin
        if (!kt_out_valid) eseq_d = 1'b1;
      end
    endcase

    if (out_beat) begin
      rv_d    = 1'b1;
      rid_d   = owner_q;
      rx_d    = kt_out_x;
      ry_d    = kt_out_y;
      rstep_d = kt_move_out;
      if (kt_move_out != exp_q) eseq_d = 1'b1;
      if (drain_last) begin
        rlast_d      = 1'b1;
        jobs_d       = jobs_q + 16'd1;
        gnt_d        = '0;
        last_grant_d = owner_q;
      end else begin
        exp_d = exp_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      mv_q         <= '0;
      prio_q       <= '0;
      beat_q       <= '0;
      wdog_q       <= '0;
      exp_q        <= 5'd1;
      kin_valid_q  <= 1'b0;
      kin_x_q      <= '0;
      kin_y_q      <= '0;
      kin_mv_q     <= '0;
      kin_prio_q   <= '0;
      rv_q         <= 1'b0;
      rlast_q      <= 1'b0;
      rid_q        <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      rstep_q      <= '0;
      eproto_q     <= 1'b0;
      ecfg_q       <= 1'b0;
      eseq_q       <= 1'b0;
      eto_q        <= 1'b0;
      jobs_q       <= '0;
    end else begin
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mv_q         <= mv_d;
      prio_q       <= prio_d;
      beat_q       <= beat_d;
      wdog_q       <= wdog_d;
      exp_q        <= exp_d;
      kin_valid_q  <= kin_valid_d;
      kin_x_q      <= kin_x_d;
      kin_y_q      <= kin_y_d;
      kin_mv_q     <= kin_mv_d;
      kin_prio_q   <= kin_prio_d;
      rv_q         <= rv_d;
      rlast_q      <= rlast_d;
      rid_q        <= rid_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      rstep_q      <= rstep_d;
      eproto_q     <= eproto_d;
      ecfg_q       <= ecfg_d;
      eseq_q       <= eseq_d;
      eto_q        <= eto_d;
      jobs_q       <= jobs_d;
    end
  end

  assign gnt             = gnt_q;
  assign kt_in_valid     = kin_valid_q;
  assign kt_in_x         = kin_x_q;
  assign kt_in_y         = kin_y_q;
  assign kt_move_num     = kin_mv_q;
  assign kt_priority_num = kin_prio_q;
  assign r_valid         = rv_q;
  assign r_id            = rid_q;
  assign r_x             = rx_q;
  assign r_y             = ry_q;
  assign r_step          = rstep_q;
  assign r_last          = rlast_q;
  assign err_proto       = eproto_q;
  assign err_cfg         = ecfg_q;
  assign err_seq         = eseq_q;
  assign err_timeout     = eto_q;
  assign job_cnt         = jobs_q;

endmodule
`default_nettype wire

// File: tb/tb_kt_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kt_job_arbiter
// Purpose  : Self-checking bench for kt_job_arbiter. Table-driven single-job
//            rows plus hand-written reset-mid-drain and round-robin sequences.
//            A behavioural requester and core model runs on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kt_job_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk, rst_n;
  logic [NREQ-1:0]   req, gnt, s_valid, s_ready;
  logic [3*NREQ-1:0] s_x, s_y, s_prio;
  logic [5*NREQ-1:0] s_move_num;
  logic              kt_in_valid;
  logic [2:0]        kt_in_x, kt_in_y, kt_priority_num;
  logic [4:0]        kt_move_num;
  logic              kt_out_valid;
  logic [2:0]        kt_out_x, kt_out_y;
  logic [4:0]        kt_move_out;
  logic              r_valid, r_last;
  logic [IDW-1:0]    r_id;
  logic [2:0]        r_x, r_y;
  logic [4:0]        r_step;
  logic              err_proto, err_cfg, err_seq, err_timeout, err_clr;
  logic [15:0]       job_cnt;

  kt_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(16'd30)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .s_move_num(s_move_num), .s_prio(s_prio),
    .kt_in_valid(kt_in_valid), .kt_in_x(kt_in_x), .kt_in_y(kt_in_y),
    .kt_move_num(kt_move_num), .kt_priority_num(kt_priority_num),
    .kt_out_valid(kt_out_valid), .kt_out_x(kt_out_x), .kt_out_y(kt_out_y),
    .kt_move_out(kt_move_out),
    .r_valid(r_valid), .r_id(r_id), .r_x(r_x), .r_y(r_y), .r_step(r_step),
    .r_last(r_last),
    .err_proto(err_proto), .err_cfg(err_cfg), .err_seq(err_seq),
    .err_timeout(err_timeout), .err_clr(err_clr), .job_cnt(job_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Environment state
  int rq_mv[NREQ], rq_prio[NREQ], rq_nb[NREQ], rq_sent[NREQ];
  logic [NREQ-1:0] pg;
  int cst, cd, cb, core_delay, fault_beat, fault_val;
  int kin_cnt, rcnt, lastcnt, exp_id, cur_mv, cur_prio;

  typedef struct {
    logic [1:0] req;
    int mv, prio, nb, dly, fbeat, fval;
    int owner, kin, rb, lastn, ecfg, eproto, eseq, eto, jobs;
  } row_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: observe outputs at negedge, then drive the core and requesters
  task automatic tick();
    @(negedge clk);
    if (kt_in_valid) begin
      chk("kin_x", kt_in_x, kin_cnt % 8);
      chk("kin_y", kt_in_y, (kin_cnt + 3) % 8);
      chk("kin_mv", kt_move_num, cur_mv);
      chk("kin_prio", kt_priority_num, cur_prio);
      kin_cnt++;
      cst = 1;
    end else if (cst == 1) begin
      cst = 2;
      cd  = core_delay;
    end else if (cst == 2) begin
      if (cd == 0) begin cst = 3; cb = 1; end
      else cd--;
    end
    if (r_valid) begin
      rcnt++;
      chk("r_id", r_id, exp_id);
      chk("r_x", r_x, rcnt % 8);
      chk("r_y", r_y, (rcnt * 3) % 8);
      chk("r_step", r_step, (rcnt == fault_beat) ? fault_val : rcnt);
      chk("r_last", r_last, (rcnt == 25) ? 1 : 0);
      if (r_last) lastcnt++;
    end
    kt_out_valid = 1'b0;
    if (cst == 3) begin
      kt_out_valid = 1'b1;
      kt_out_x     = 3'(cb % 8);
      kt_out_y     = 3'((cb * 3) % 8);
      kt_move_out  = (cb == fault_beat) ? 5'(fault_val) : 5'(cb);
      cb++;
      if (cb == 26) cst = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && !pg[i]) rq_sent[i] = 0;
      s_valid[i]          = s_ready[i] && (rq_sent[i] < rq_nb[i]);
      s_x[3*i +: 3]        = 3'd7;
      s_y[3*i +: 3]        = 3'd7;
      s_move_num[5*i +: 5] = 5'd31;
      s_prio[3*i +: 3]     = 3'd7;
      if (s_valid[i]) begin
        s_x[3*i +: 3]        = 3'(rq_sent[i] % 8);
        s_y[3*i +: 3]        = 3'((rq_sent[i] + 3) % 8);
        s_move_num[5*i +: 5] = (rq_sent[i] == 0) ? 5'(rq_mv[i]) : 5'd31;
        s_prio[3*i +: 3]     = (rq_sent[i] == 0) ? 3'(rq_prio[i]) : 3'(7 - rq_prio[i]);
        rq_sent[i]++;
      end
    end
    pg = gnt;
  endtask

  task automatic wait_gnt(input string nm, input bit want_set, input int bound);
    int n = 0;
    while (((gnt != 0) != want_set) && n < bound) begin tick(); n++; end
    total++;
    if ((gnt != 0) != want_set) begin
      bad++;
      $display("FAIL %s: gnt=%b after %0d cycles, expected %s", nm, gnt, n,
               want_set ? "nonzero" : "zero");
    end
  endtask

  task automatic set_job(input int mv, input int prio, input int nb, input int dly,
                         input int fb, input int fv);
    for (int i = 0; i < NREQ; i++) begin
      rq_mv[i] = mv; rq_prio[i] = prio; rq_nb[i] = nb;
    end
    core_delay = dly; fault_beat = fb; fault_val = fv;
    cur_mv = mv; cur_prio = prio;
    kin_cnt = 0; rcnt = 0; lastcnt = 0;
  endtask

  row_t tbl[8];

  initial begin
    tbl[0] = '{2'b01,  1, 0,  1,  2, 0, 0, 0,  1, 25, 1, 0, 0, 0, 0, 1};
    tbl[1] = '{2'b11,  3, 5,  3,  2, 0, 0, 1,  3, 25, 1, 0, 0, 0, 0, 2};
    tbl[2] = '{2'b11,  0, 1,  1,  2, 0, 0, 0,  0,  0, 0, 1, 0, 0, 0, 2};
    tbl[3] = '{2'b11, 25, 1,  1,  2, 0, 0, 0,  0,  0, 0, 1, 0, 0, 0, 2};
    tbl[4] = '{2'b10, 24, 7, 24,  2, 0, 0, 1, 24, 25, 1, 0, 0, 0, 0, 3};
    tbl[5] = '{2'b11,  5, 3,  3,  2, 0, 0, 0,  3, 25, 1, 0, 1, 0, 0, 4};
    tbl[6] = '{2'b11,  2, 2,  2,  2, 6, 7, 1,  2, 25, 1, 0, 0, 1, 0, 5};
    tbl[7] = '{2'b01,  1, 4,  1, 50, 0, 0, 0,  1, 25, 1, 0, 0, 0, 1, 6};

    rst_n = 1'b0; req = '0; s_valid = '0; s_x = '0; s_y = '0;
    s_move_num = '0; s_prio = '0; err_clr = 1'b0;
    kt_out_valid = 1'b0; kt_out_x = '0; kt_out_y = '0; kt_move_out = '0;
    pg = '0; cst = 0; cd = 0; cb = 0; exp_id = 0;
    for (int i = 0; i < NREQ; i++) rq_sent[i] = 0;
    set_job(1, 0, 1, 2, 0, 0);

    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_kin_valid", kt_in_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_job_cnt", job_cnt, 0);
    chk("rst_errs", {err_proto, err_cfg, err_seq, err_timeout}, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven single jobs
    for (int r = 0; r < 8; r++) begin
      set_job(tbl[r].mv, tbl[r].prio, tbl[r].nb, tbl[r].dly, tbl[r].fbeat, tbl[r].fval);
      exp_id = tbl[r].owner;
      req    = tbl[r].req;
      wait_gnt($sformatf("row%0d_gnt_set", r), 1'b1, 20);
      chk($sformatf("row%0d_gnt", r), gnt, 1 << tbl[r].owner);
      req = '0;
      wait_gnt($sformatf("row%0d_gnt_clr", r), 1'b0, 400);
      repeat (3) tick();
      chk($sformatf("row%0d_kin_beats", r), kin_cnt, tbl[r].kin);
      chk($sformatf("row%0d_r_beats", r), rcnt, tbl[r].rb);
      chk($sformatf("row%0d_r_last", r), lastcnt, tbl[r].lastn);
      chk($sformatf("row%0d_err_cfg", r), err_cfg, tbl[r].ecfg);
      chk($sformatf("row%0d_err_proto", r), err_proto, tbl[r].eproto);
      chk($sformatf("row%0d_err_seq", r), err_seq, tbl[r].eseq);
      chk($sformatf("row%0d_err_timeout", r), err_timeout, tbl[r].eto);
      chk($sformatf("row%0d_job_cnt", r), job_cnt, tbl[r].jobs);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      chk($sformatf("row%0d_err_clr", r), {err_proto, err_cfg, err_seq, err_timeout}, 0);
    end

    // Reset in the middle of a result burst
    set_job(1, 0, 1, 2, 0, 0);
    exp_id = 0;
    req = 2'b01;
    wait_gnt("mid_rst_gnt_set", 1'b1, 20);
    req = '0;
    begin
      int n = 0;
      while (rcnt < 10 && n < 200) begin tick(); n++; end
      chk("mid_rst_reached_drain", (rcnt >= 10) ? 1 : 0, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_kin_valid", kt_in_valid, 0);
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_r_step", r_step, 0);
    chk("mid_rst_job_cnt", job_cnt, 0);
    cst = 0; kt_out_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Round-robin with both requests held: 0, 1, 0
    set_job(2, 1, 2, 2, 0, 0);
    req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_gnt($sformatf("rr%0d_gnt_set", j), 1'b1, 20);
      chk($sformatf("rr%0d_gnt", j), gnt, (j % 2 == 0) ? 1 : 2);
      exp_id = (j % 2 == 0) ? 0 : 1;
      kin_cnt = 0; rcnt = 0; lastcnt = 0;
      wait_gnt($sformatf("rr%0d_gnt_clr", j), 1'b0, 400);
      chk($sformatf("rr%0d_kin_beats", j), kin_cnt, 2);
      chk($sformatf("rr%0d_r_beats", j), rcnt, 25);
      chk($sformatf("rr%0d_r_last", j), lastcnt, 1);
    end
    req = '0;
    repeat (4) tick();
    chk("rr_job_cnt", job_cnt, 3);
    chk("rr_errs", {err_proto, err_cfg, err_seq, err_timeout}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
